nios_ifetch_queue: RTL and testbench

- Parametrised instruction store plus prefetch unit for the nios_2 core. It replaces the single registered instruction word the core used to receive on inst_fetch.
- Owns the fetch PC and reads sequential words from an internal instruction RAM into a QDEPTH-entry prefetch queue.
- Presents the head entry to the core with a valid/enable handshake.
- Supports PC redirect (branch/jump flush) and a program-load write port for boot and benches.

---
 rtl/nios_ifetch_queue_if.sv | 30 +++
 rtl/nios_ifetch_queue.sv | 132 +++++++++++++
 tb/tb_nios_ifetch_queue.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/nios_ifetch_queue_if.sv
// rtl/nios_ifetch_queue_if.sv - core/boot-side signal bundle for nios_ifetch_queue
interface nios_ifetch_queue_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 8,
   parameter int QDEPTH = 4
);
   localparam int CW = $clog2(QDEPTH) + 1;

   logic              enable;
   logic              redirect;
   logic [ADDR_W-1:0] redirect_pc;
   logic              ld_we;
   logic [ADDR_W-1:0] ld_addr;
   logic [DATA_W-1:0] ld_data;
   logic [DATA_W-1:0] inst_o;
   logic [ADDR_W-1:0] pc_o;
   logic              inst_valid_o;
   logic [CW-1:0]     q_count_o;
   logic              parity_err_o;

   modport master (
      output enable, redirect, redirect_pc, ld_we, ld_addr, ld_data,
      input  inst_o, pc_o, inst_valid_o, q_count_o, parity_err_o
   );

   modport slave (
      input  enable, redirect, redirect_pc, ld_we, ld_addr, ld_data,
      output inst_o, pc_o, inst_valid_o, q_count_o, parity_err_o
   );
endinterface

// File: rtl/nios_ifetch_queue.sv
// rtl/nios_ifetch_queue.sv - instruction RAM plus prefetch queue; IFETCH_PARITY_EN adds per-word even parity
module nios_ifetch_queue #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 8,
   parameter int QDEPTH   = 4,
   parameter int RESET_PC = 0
) (
   input logic             clk,
   input logic             rst,
   nios_ifetch_queue_if.slave bus
);
   localparam int PW    = $clog2(QDEPTH);
   localparam int CW    = PW + 1;
   localparam int DEPTH = 2 ** ADDR_W;
`ifdef IFETCH_PARITY_EN
   localparam int MW = DATA_W + 1;
`else
   localparam int MW = DATA_W;
`endif

   logic [MW-1:0]     mem [DEPTH];
   logic [MW-1:0]     rdata_q;
   logic [MW-1:0]     ld_word;

   logic [ADDR_W-1:0] fpc_q, fpc_d;
   logic [ADDR_W-1:0] ipc_q, ipc_d;
   logic              inflight_q, inflight_d;
   logic [PW-1:0]     wr_q, wr_d;
   logic [PW-1:0]     rd_q, rd_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [DATA_W-1:0] qd_q [QDEPTH];
   logic [DATA_W-1:0] qd_d [QDEPTH];
   logic [ADDR_W-1:0] qp_q [QDEPTH];
   logic [ADDR_W-1:0] qp_d [QDEPTH];
`ifdef IFETCH_PARITY_EN
   logic [QDEPTH-1:0] qe_q, qe_d;
`endif

   logic issue, push, pop, valid;

`ifdef IFETCH_PARITY_EN
   assign ld_word = {^bus.ld_data, bus.ld_data};
`else
   assign ld_word = bus.ld_data;
`endif

   assign valid = (cnt_q != '0);
   // Credit counts the in-flight read but ignores a same-edge pop, so the tail can never be overrun.
   assign issue = !bus.redirect && ((cnt_q + CW'(inflight_q)) < CW'(QDEPTH));
   assign push  = inflight_q && !bus.redirect;
   assign pop   = bus.enable && valid && !bus.redirect;

   always_ff @(posedge clk) begin
      if (bus.ld_we) mem[bus.ld_addr] <= ld_word;
      if (issue)     rdata_q <= mem[fpc_q];
   end

   always_comb begin
      fpc_d      = fpc_q;
      ipc_d      = ipc_q;
      inflight_d = issue;
      wr_d       = wr_q;
      rd_d       = rd_q;
      cnt_d      = cnt_q;
      qd_d       = qd_q;
      qp_d       = qp_q;
`ifdef IFETCH_PARITY_EN
      qe_d       = qe_q;
`endif
      if (issue) begin
         ipc_d = fpc_q;
         fpc_d = fpc_q + 1'b1;
      end
      if (push) begin
         qd_d[wr_q] = rdata_q[DATA_W-1:0];
         qp_d[wr_q] = ipc_q;
`ifdef IFETCH_PARITY_EN
         qe_d[wr_q] = (^rdata_q[DATA_W-1:0]) != rdata_q[DATA_W];
`endif
         wr_d = wr_q + 1'b1;
      end
      if (pop) rd_d = rd_q + 1'b1;
      cnt_d = cnt_q + CW'(push) - CW'(pop);
      // Redirect wins: drop queue, ignore pop, and the cleared in-flight flag kills the pending capture.
      if (bus.redirect) begin
         fpc_d = bus.redirect_pc;
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fpc_q      <= ADDR_W'(RESET_PC);
         ipc_q      <= '0;
         inflight_q <= 1'b0;
         wr_q       <= '0;
         rd_q       <= '0;
         cnt_q      <= '0;
         for (int i = 0; i < QDEPTH; i++) begin
            qd_q[i] <= '0;
            qp_q[i] <= '0;
         end
`ifdef IFETCH_PARITY_EN
         qe_q       <= '0;
`endif
      end else begin
         fpc_q      <= fpc_d;
         ipc_q      <= ipc_d;
         inflight_q <= inflight_d;
         wr_q       <= wr_d;
         rd_q       <= rd_d;
         cnt_q      <= cnt_d;
         qd_q       <= qd_d;
         qp_q       <= qp_d;
`ifdef IFETCH_PARITY_EN
         qe_q       <= qe_d;
`endif
      end
   end

   assign bus.inst_valid_o = valid;
   assign bus.q_count_o    = cnt_q;
   assign bus.inst_o       = valid ? qd_q[rd_q] : '0;
   assign bus.pc_o         = valid ? qp_q[rd_q] : ADDR_W'(RESET_PC);
`ifdef IFETCH_PARITY_EN
   assign bus.parity_err_o = valid & qe_q[rd_q];
`else
   assign bus.parity_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_nios_ifetch_queue.sv
// tb/tb_nios_ifetch_queue.sv - directed scoreboard bench for nios_ifetch_queue
module tb_nios_ifetch_queue;
   localparam int DW = 32;
   localparam int AW = 8;
   localparam int QD = 4;

   typedef struct packed {
      logic [AW-1:0] pc;
      logic [DW-1:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst0, rst1;
   int   tests = 0;
   int   fails = 0;
   int   bad_pc = -1;
   logic [DW-1:0] mem0 [256];
   logic [DW-1:0] mem1 [8];
   exp_t sb [$];

   always #5 clk = ~clk;

   nios_ifetch_queue_if #(.DATA_W(DW), .ADDR_W(AW), .QDEPTH(QD)) b0 ();
   nios_ifetch_queue_if #(.DATA_W(DW), .ADDR_W(3),  .QDEPTH(QD)) b1 ();

   nios_ifetch_queue #(.DATA_W(DW), .ADDR_W(AW), .QDEPTH(QD), .RESET_PC(0)) u0 (
      .clk(clk), .rst(rst0), .bus(b0));
   nios_ifetch_queue #(.DATA_W(DW), .ADDR_W(3), .QDEPTH(QD), .RESET_PC(6)) u1 (
      .clk(clk), .rst(rst1), .bus(b1));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ld0(input int a, input logic [DW-1:0] d);
      b0.ld_we   = 1'b1;
      b0.ld_addr = AW'(a);
      b0.ld_data = d;
      tick();
      b0.ld_we   = 1'b0;
      mem0[a]    = d;
   endtask

   task automatic push_seq(input int first, input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.pc   = AW'(first + i);
         e.data = mem0[(first + i) % 256];
         sb.push_back(e);
      end
   endtask

   // Compare the head the DUT is presenting (it is consumed at the next edge) with the scoreboard front.
   task automatic pop0(input string tag);
      exp_t e;
      logic ep;
      if (sb.size() == 0) begin
         chk({tag, "_sb_underflow"}, 64'(sb.size()), 64'd1);
      end else begin
         e = sb.pop_front();
`ifdef IFETCH_PARITY_EN
         ep = (int'(e.pc) == bad_pc);
`else
         ep = 1'b0;
`endif
         chk({tag, "_valid"}, 64'(b0.inst_valid_o), 64'd1);
         chk({tag, "_pc"},    64'(b0.pc_o),         64'(e.pc));
         chk({tag, "_inst"},  64'(b0.inst_o),       64'(e.data));
         chk({tag, "_perr"},  64'(b0.parity_err_o), 64'(ep));
      end
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst0 = 1'b0; rst1 = 1'b0;
      b0.enable = 0; b0.redirect = 0; b0.redirect_pc = '0; b0.ld_we = 0; b0.ld_addr = '0; b0.ld_data = '0;
      b1.enable = 0; b1.redirect = 0; b1.redirect_pc = '0; b1.ld_we = 0; b1.ld_addr = '0; b1.ld_data = '0;
      tick();

      for (int i = 0; i < 16; i++) ld0(i, $urandom);
      for (int i = 32; i < 36; i++) ld0(i, $urandom);
      for (int i = 0; i < 8; i++) begin
         mem1[i]    = $urandom;
         b1.ld_we   = 1'b1;
         b1.ld_addr = 3'(i);
         b1.ld_data = mem1[i];
         tick();
      end
      b1.ld_we = 1'b0;

      chk("rst_valid", 64'(b0.inst_valid_o), 64'd0);
      chk("rst_inst",  64'(b0.inst_o),       64'd0);
      chk("rst_pc",    64'(b0.pc_o),         64'd0);
      chk("rst_count", 64'(b0.q_count_o),    64'd0);
      chk("rst_perr",  64'(b0.parity_err_o), 64'd0);

      // Stream from reset with enable held high.
      b0.enable = 1'b1;
      rst0 = 1'b1;
      tick();
      chk("a_edge1_valid", 64'(b0.inst_valid_o), 64'd0);
      tick();
      push_seq(0, 8);
      for (int i = 0; i < 8; i++) pop0("a_stream");

      // Fill with enable low, then drain.
      rst0 = 1'b0; b0.enable = 1'b0; sb.delete();
      tick();
      rst0 = 1'b1;
      repeat (6) tick();
      chk("b_count_full", 64'(b0.q_count_o), 64'd4);
      chk("b_hold_pc",    64'(b0.pc_o),      64'd0);
      chk("b_hold_inst",  64'(b0.inst_o),    64'(mem0[0]));
      tick();
      chk("b_count_sat",  64'(b0.q_count_o), 64'd4);
      push_seq(0, 12);
      b0.enable = 1'b1;
      for (int i = 0; i < 12; i++) pop0("b_drain");

      // Redirect with three queued entries and one read in flight.
      rst0 = 1'b0; b0.enable = 1'b0; sb.delete();
      tick();
      rst0 = 1'b1;
      repeat (4) tick();
      chk("c_count_pre", 64'(b0.q_count_o), 64'd3);
      b0.redirect = 1'b1; b0.redirect_pc = 8'h20;
      tick();
      b0.redirect = 1'b0;
      chk("c_flush_count", 64'(b0.q_count_o),    64'd0);
      chk("c_flush_valid", 64'(b0.inst_valid_o), 64'd0);
      chk("c_flush_inst",  64'(b0.inst_o),       64'd0);
      tick();
      chk("c_n1_valid", 64'(b0.inst_valid_o), 64'd0);
      tick();
      push_seq(32, 4);
      b0.enable = 1'b1;
      for (int i = 0; i < 4; i++) pop0("c_redir");

      // Asynchronous reset mid-stream.
      rst0 = 1'b0; b0.enable = 1'b0; sb.delete();
      tick();
      rst0 = 1'b1;
      repeat (3) tick();
      chk("d_count_pre", 64'(b0.q_count_o), 64'd2);
      #2 rst0 = 1'b0;
      #1;
      chk("d_async_valid", 64'(b0.inst_valid_o), 64'd0);
      chk("d_async_count", 64'(b0.q_count_o),    64'd0);
      chk("d_async_inst",  64'(b0.inst_o),       64'd0);
      chk("d_async_pc",    64'(b0.pc_o),         64'd0);
      tick();
      rst0 = 1'b1; b0.enable = 1'b1;
      tick();
      tick();
      push_seq(0, 4);
      for (int i = 0; i < 4; i++) pop0("d_restart");

      // Parity: corrupt the stored parity bit of word 5 behind the load port.
      rst0 = 1'b0; b0.enable = 1'b0; sb.delete();
`ifdef IFETCH_PARITY_EN
      u0.mem[5] = u0.mem[5] ^ {1'b1, {DW{1'b0}}};
      bad_pc = 5;
`endif
      tick();
      rst0 = 1'b1; b0.enable = 1'b1;
      tick();
      tick();
      push_seq(0, 8);
      for (int i = 0; i < 8; i++) pop0("e_parity");

      // Small-RAM instance starting at 6 wraps to 0.
      b1.enable = 1'b1;
      rst1 = 1'b1;
      tick();
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("f_wrap_valid", 64'(b1.inst_valid_o), 64'd1);
         chk("f_wrap_pc",    64'(b1.pc_o),         64'((6 + i) % 8));
         chk("f_wrap_inst",  64'(b1.inst_o),       64'(mem1[(6 + i) % 8]));
         chk("f_wrap_perr",  64'(b1.parity_err_o), 64'd0);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
